decode_writeback: RTL

- SEQ decode/writeback stage: sits directly downstream of fetch and consumes its icode, rA and rB.
- Selects source and destination register IDs, reads valA/valB from the 15-entry x 64-bit Y86 register file, and commits valE/valM on the clock edge.
- Register file state is the only sequential state; read paths are combinational off current state.

---
 rtl/y86_pkg.sv | 36 +++
 rtl/regfile_15x64.sv | 61 ++++++
 rtl/decode_writeback.sv | 106 ++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 decode constants: instruction codes and register IDs.
package y86_pkg;

    localparam int unsigned ID_W = 4;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] R_RAX = 4'h0;
    localparam logic [3:0] R_RCX = 4'h1;
    localparam logic [3:0] R_RDX = 4'h2;
    localparam logic [3:0] R_RBX = 4'h3;
    localparam logic [3:0] RSP   = 4'h4;
    localparam logic [3:0] R_RBP = 4'h5;
    localparam logic [3:0] R_RSI = 4'h6;
    localparam logic [3:0] R_RDI = 4'h7;
    localparam logic [3:0] R_R8  = 4'h8;
    localparam logic [3:0] R_R9  = 4'h9;
    localparam logic [3:0] R_R10 = 4'hA;
    localparam logic [3:0] R_R11 = 4'hB;
    localparam logic [3:0] R_R12 = 4'hC;
    localparam logic [3:0] R_R13 = 4'hD;
    localparam logic [3:0] R_R14 = 4'hE;
    localparam logic [3:0] RNONE = 4'hF;

endpackage

// File: rtl/regfile_15x64.sv
// 15-entry Y86 register file: two async read ports plus debug port,
// two sync write ports with M taking priority over E on collision.
module regfile_15x64
    import y86_pkg::*;
#(
    parameter int unsigned DATA_W   = 64,
    parameter logic [63:0] RSP_INIT = 64'd1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [ID_W-1:0]   i_dst_e,
    input  logic [DATA_W-1:0] i_val_e,
    input  logic [ID_W-1:0]   i_dst_m,
    input  logic [DATA_W-1:0] i_val_m,
    input  logic [ID_W-1:0]   i_src_a,
    input  logic [ID_W-1:0]   i_src_b,
    input  logic [ID_W-1:0]   i_dbg_sel,
    output logic [DATA_W-1:0] o_val_a,
    output logic [DATA_W-1:0] o_val_b,
    output logic [DATA_W-1:0] o_dbg_val
);

    localparam int unsigned NREGS = 15;

    logic [DATA_W-1:0] r_regs [NREGS];

    // M write placed after E so it wins when both target the same register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_regs[RSP] <= DATA_W'(RSP_INIT);
        end else if (i_wr_en) begin
            if (i_dst_e != RNONE) begin
                r_regs[i_dst_e] <= i_val_e;
            end
            if (i_dst_m != RNONE) begin
                r_regs[i_dst_m] <= i_val_m;
            end
        end
    end

    // Index F has no storage and reads as zero
    always_comb begin
        o_val_a   = '0;
        o_val_b   = '0;
        o_dbg_val = '0;
        if (i_src_a != RNONE) begin
            o_val_a = r_regs[i_src_a];
        end
        if (i_src_b != RNONE) begin
            o_val_b = r_regs[i_src_b];
        end
        if (i_dbg_sel != RNONE) begin
            o_dbg_val = r_regs[i_dbg_sel];
        end
    end

endmodule

// File: rtl/decode_writeback.sv
// SEQ decode/writeback stage: selects register IDs from icode/rA/rB and
// drives the register file read and writeback ports.
module decode_writeback
    import y86_pkg::*;
#(
    parameter logic [63:0] RSP_INIT = 64'd1000,
    parameter int unsigned DATA_W   = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        icode,
    input  logic [3:0]        rA,
    input  logic [3:0]        rB,
    input  logic              cnd,
    input  logic [DATA_W-1:0] valE,
    input  logic [DATA_W-1:0] valM,
    input  logic              wb_en,
    output logic [3:0]        srcA,
    output logic [3:0]        srcB,
    output logic [3:0]        dstE,
    output logic [3:0]        dstM,
    output logic [DATA_W-1:0] valA,
    output logic [DATA_W-1:0] valB,
    input  logic [3:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_val
);

    logic [3:0] w_src_a;
    logic [3:0] w_src_b;
    logic [3:0] w_dst_e;
    logic [3:0] w_dst_m;

    // Register ID selection; anything not listed (halt, nop, jXX, invalid) uses none
    always_comb begin
        w_src_a = RNONE;
        w_src_b = RNONE;
        w_dst_e = RNONE;
        w_dst_m = RNONE;
        case (icode)
            I_RRMOVQ: begin
                w_src_a = rA;
                w_dst_e = cnd ? rB : RNONE;
            end
            I_IRMOVQ: w_dst_e = rB;
            I_RMMOVQ: begin
                w_src_a = rA;
                w_src_b = rB;
            end
            I_MRMOVQ: begin
                w_src_b = rB;
                w_dst_m = rA;
            end
            I_OPQ: begin
                w_src_a = rA;
                w_src_b = rB;
                w_dst_e = rB;
            end
            I_CALL: begin
                w_src_b = RSP;
                w_dst_e = RSP;
            end
            I_RET: begin
                w_src_a = RSP;
                w_src_b = RSP;
                w_dst_e = RSP;
            end
            I_PUSHQ: begin
                w_src_a = rA;
                w_src_b = RSP;
                w_dst_e = RSP;
            end
            I_POPQ: begin
                w_src_a = RSP;
                w_src_b = RSP;
                w_dst_e = RSP;
                w_dst_m = rA;
            end
            default: ;
        endcase
    end

    assign srcA = w_src_a;
    assign srcB = w_src_b;
    assign dstE = w_dst_e;
    assign dstM = w_dst_m;

    regfile_15x64 #(
        .DATA_W   (DATA_W),
        .RSP_INIT (RSP_INIT)
    ) u_regfile (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (wb_en),
        .i_dst_e   (w_dst_e),
        .i_val_e   (valE),
        .i_dst_m   (w_dst_m),
        .i_val_m   (valM),
        .i_src_a   (w_src_a),
        .i_src_b   (w_src_b),
        .i_dbg_sel (dbg_sel),
        .o_val_a   (valA),
        .o_val_b   (valB),
        .o_dbg_val (dbg_val)
    );

endmodule
